// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU controller: op codes, flag/error bit
// positions and the controller state encoding.
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } op_e;

    localparam int FLAG_CARRY    = 3;
    localparam int FLAG_OVF      = 2;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_NEGATIVE = 0;

    localparam int ERR_DATA = 2;
    localparam int ERR_CRC  = 1;
    localparam int ERR_OP   = 0;

    typedef enum logic [2:0] {
        IDLE,
        RX,
        CHECK,
        REQ,
        TX_DATA,
        TX_CTL,
        TX_ERR
    } state_e;

    function automatic logic op_is_valid(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mtm_alu_ctl_if.sv
// Byte-stream, ALU request and serializer signals of the MTM ALU controller.
// master = controller side, slave = surrounding environment.
interface mtm_alu_ctl_if;
    logic        rx_valid;
    logic        rx_cmd;
    logic [7:0]  rx_data;
    logic        alu_req;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic        alu_ack;
    logic [31:0] alu_c;
    logic [3:0]  alu_flags;
    logic        tx_valid;
    logic        tx_cmd;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        input  rx_valid, rx_cmd, rx_data, alu_ack, alu_c, alu_flags, tx_ready,
        output alu_req, alu_a, alu_b, alu_op, tx_valid, tx_cmd, tx_data
    );

    modport slave (
        output rx_valid, rx_cmd, rx_data, alu_ack, alu_c, alu_flags, tx_ready,
        input  alu_req, alu_a, alu_b, alu_op, tx_valid, tx_cmd, tx_data
    );
endinterface

// File: rtl/mtm_alu_crc.sv
// Combinational CRC4 (x^4+x+1) over the request packet and CRC3 (x^3+x+1)
// over the response; both MSB first with zero initial value.
module mtm_alu_crc
    import mtm_alu_pkg::*;
(
    input  logic [63:0] ba,
    input  logic [2:0]  op,
    input  logic [31:0] c,
    input  logic [3:0]  flags,
    output logic [3:0]  crc4,
    output logic [2:0]  crc3
);
    logic [67:0] msg4;
    logic [36:0] msg3;
    logic [3:0]  r4;
    logic [2:0]  r3;

    always_comb begin
        msg4 = {ba, 1'b0, op};
        msg3 = {c, 1'b0, flags};
        r4   = '0;
        r3   = '0;
        for (int i = 67; i >= 0; i--) begin
            r4 = {r4[2:0], 1'b0} ^ ({4{r4[3] ^ msg4[i]}} & 4'b0011);
        end
        for (int i = 36; i >= 0; i--) begin
            r3 = {r3[1:0], 1'b0} ^ ({3{r3[2] ^ msg3[i]}} & 3'b011);
        end
        crc4 = r4;
        crc3 = r3;
    end
endmodule

// File: rtl/mtm_alu_ctl.sv
// MTM ALU controller: collects B/A bytes and a command byte, validates them,
// runs one ALU operation and streams the result (or an error byte) back out.
module mtm_alu_ctl
    import mtm_alu_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    mtm_alu_ctl_if.master bus
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] data_q, data_d;
    logic [2:0]  op_rx_q, op_rx_d;
    logic [3:0]  crc_rx_q, crc_rx_d;
    logic [2:0]  err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0] res_c_q, res_c_d;
    logic [3:0]  res_flags_q, res_flags_d;
    logic [1:0]  idx_q, idx_d;
    logic        alu_req_q, alu_req_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        tx_valid_q, tx_valid_d;
    logic        tx_cmd_q, tx_cmd_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic [3:0]  crc4;
    logic [2:0]  crc3;
    logic [2:0]  err_check;
    logic        ack_timeout;
    logic        tx_done;

    mtm_alu_crc u_crc (
        .ba    (data_q),
        .op    (op_rx_q),
        .c     (res_c_q),
        .flags (res_flags_q),
        .crc4  (crc4),
        .crc3  (crc3)
    );

    // A wrong byte count makes CRC and OP meaningless, so they are skipped.
    always_comb begin
        err_check = '0;
        if (cnt_q != 4'd8) begin
            err_check[ERR_DATA] = 1'b1;
        end else begin
            err_check[ERR_CRC] = (crc4 != crc_rx_q);
            err_check[ERR_OP]  = !op_is_valid(op_rx_q);
        end
    end

    assign ack_timeout = (timer_q == TW'(ACK_TIMEOUT - 1));
    assign tx_done     = tx_valid_q && bus.tx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            op_rx_q     <= '0;
            crc_rx_q    <= '0;
            err_q       <= '0;
            timer_q     <= '0;
            res_c_q     <= '0;
            res_flags_q <= '0;
            idx_q       <= '0;
            alu_req_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tx_valid_q  <= 1'b0;
            tx_cmd_q    <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            op_rx_q     <= op_rx_d;
            crc_rx_q    <= crc_rx_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
            res_c_q     <= res_c_d;
            res_flags_q <= res_flags_d;
            idx_q       <= idx_d;
            alu_req_q   <= alu_req_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            tx_valid_q  <= tx_valid_d;
            tx_cmd_q    <= tx_cmd_d;
            tx_data_q   <= tx_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.rx_valid) state_d = bus.rx_cmd ? CHECK : RX;
            RX:      if (bus.rx_valid && bus.rx_cmd) state_d = CHECK;
            CHECK:   state_d = (err_check != 3'b000) ? TX_ERR : REQ;
            REQ: begin
                if (bus.alu_ack)  state_d = TX_DATA;
                else if (ack_timeout) state_d = IDLE;
            end
            TX_DATA: if (tx_done && idx_q == 2'd3) state_d = TX_CTL;
            TX_CTL, TX_ERR: if (tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        data_d      = data_q;
        op_rx_d     = op_rx_q;
        crc_rx_d    = crc_rx_q;
        err_d       = err_q;
        timer_d     = timer_q;
        res_c_d     = res_c_q;
        res_flags_d = res_flags_q;
        idx_d       = idx_q;
        alu_req_d   = alu_req_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        tx_valid_d  = tx_valid_q;
        tx_cmd_d    = tx_cmd_q;
        tx_data_d   = tx_data_q;
        case (state_q)
            IDLE, RX: begin
                if (bus.rx_valid && !bus.rx_cmd) begin
                    data_d = {data_q[55:0], bus.rx_data};
                    if (cnt_q != 4'd9) cnt_d = cnt_q + 4'd1;
                end else if (bus.rx_valid) begin
                    op_rx_d  = bus.rx_data[6:4];
                    crc_rx_d = bus.rx_data[3:0];
                end
            end
            CHECK: begin
                err_d = err_check;
                if (err_check != 3'b000) begin
                    tx_valid_d = 1'b1;
                    tx_cmd_d   = 1'b1;
                    tx_data_d  = {1'b1, err_check, err_check, ~^{1'b1, err_check, err_check}};
                end else begin
                    alu_req_d = 1'b1;
                    alu_b_d   = data_q[63:32];
                    alu_a_d   = data_q[31:0];
                    alu_op_d  = op_rx_q;
                    timer_d   = '0;
                end
            end
            REQ: begin
                if (bus.alu_ack) begin
                    alu_req_d   = 1'b0;
                    res_c_d     = bus.alu_c;
                    res_flags_d = bus.alu_flags;
                    tx_valid_d  = 1'b1;
                    tx_cmd_d    = 1'b0;
                    tx_data_d   = bus.alu_c[31:24];
                    idx_d       = 2'd0;
                    timer_d     = '0;
                end else if (ack_timeout) begin
                    alu_req_d = 1'b0;
                    timer_d   = '0;
                    cnt_d     = '0;
                    err_d     = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            TX_DATA: begin
                if (tx_done) begin
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0:    tx_data_d = res_c_q[23:16];
                        2'd1:    tx_data_d = res_c_q[15:8];
                        2'd2:    tx_data_d = res_c_q[7:0];
                        default: begin
                            tx_cmd_d  = 1'b1;
                            tx_data_d = {1'b0, res_flags_q, crc3};
                        end
                    endcase
                end
            end
            TX_CTL, TX_ERR: begin
                if (tx_done) begin
                    tx_valid_d = 1'b0;
                    tx_cmd_d   = 1'b0;
                    tx_data_d  = '0;
                    cnt_d      = '0;
                    err_d      = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.alu_req  = alu_req_q;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_op   = alu_op_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_cmd   = tx_cmd_q;
    assign bus.tx_data  = tx_data_q;
endmodule
